// File: rtl/enc_dec_hamming_encoder.sv
// Sequential Hamming SECDED encoder: builds an 8/16/32-bit codeword one position per cycle.
// Optional feature macro ENC_NOISE_EN: XOR a latched noise pattern onto the codeword.
module enc_dec_hamming_encoder #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [1:0]            codeword_width,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [DATA_WIDTH-1:0] noise,
    output logic                  busy,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  operation_done
);

    typedef enum logic [1:0] {IDLE, CALC, FINAL} state_t;

    state_t                state;
    logic [CNT_WIDTH-1:0]  counter;
    logic [CNT_WIDTH-1:0]  last_pos;
    logic [CNT_WIDTH-1:0]  acc;
    logic [DATA_WIDTH-1:0] data_sh;
    logic [DATA_WIDTH-1:0] cw;

    logic [CNT_WIDTH-1:0]  cnt_next;
    logic [CNT_WIDTH-1:0]  idx;
    logic                  is_parity;
    logic [CNT_WIDTH-1:0]  acc_f;
    logic [DATA_WIDTH-1:0] cw_f;
    logic [DATA_WIDTH-1:0] result;

`ifdef ENC_NOISE_EN
    logic [DATA_WIDTH-1:0] noise_lat;
    logic [DATA_WIDTH-1:0] noise_mask;
`else
    logic                  unused_noise;
    assign unused_noise = ^noise;
`endif

    assign cnt_next  = counter + 1'b1;
    assign idx       = counter - 1'b1;
    assign is_parity = ((counter & idx) == '0);

    // The last position (N-1) is always a data bit; it is folded in here so FINAL is the Nth cycle.
    always_comb begin
        acc_f = acc ^ (data_sh[0] ? counter : '0);
        cw_f = cw;
        cw_f[idx] = data_sh[0];
        cw_f[0]  = acc_f[0];
        cw_f[1]  = acc_f[1];
        cw_f[3]  = acc_f[2];
        cw_f[7]  = acc_f[3];
        cw_f[15] = acc_f[4];
        cw_f[last_pos] = ^cw_f;
`ifdef ENC_NOISE_EN
        noise_mask = {DATA_WIDTH{1'b1}} >> (CNT_WIDTH'(DATA_WIDTH - 1) - last_pos);
        result = cw_f ^ (noise_lat & noise_mask);
`else
        result = cw_f;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            busy           <= 1'b0;
            operation_done <= 1'b0;
            data_out       <= '0;
            counter        <= '0;
            last_pos       <= '0;
            acc            <= '0;
            data_sh        <= '0;
            cw             <= '0;
`ifdef ENC_NOISE_EN
            noise_lat      <= '0;
`endif
        end else begin
            operation_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        data_sh <= data_in;
`ifdef ENC_NOISE_EN
                        noise_lat <= noise;
`endif
                        case (codeword_width)
                            2'd0:    last_pos <= CNT_WIDTH'(7);
                            2'd1:    last_pos <= CNT_WIDTH'(15);
                            default: last_pos <= CNT_WIDTH'(31);
                        endcase
                        counter <= CNT_WIDTH'(1);
                        acc     <= '0;
                        cw      <= '0;
                        busy    <= 1'b1;
                        state   <= CALC;
                    end
                end
                CALC: begin
                    if (!is_parity) begin
                        cw[idx] <= data_sh[0];
                        if (data_sh[0])
                            acc <= acc ^ counter;
                        data_sh <= data_sh >> 1;
                    end
                    counter <= cnt_next;
                    if (cnt_next == last_pos)
                        state <= FINAL;
                end
                FINAL: begin
                    data_out       <= result;
                    operation_done <= 1'b1;
                    busy           <= 1'b0;
                    state          <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_enc_dec_hamming_encoder.sv
// Scoreboard bench for enc_dec_hamming_encoder: directed cases plus randomized encodes
// checked against a position-by-position Hamming reference model.
module tb_enc_dec_hamming_encoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  codeword_width;
    logic [31:0] data_in;
    logic [31:0] noise;
    logic        busy;
    logic [31:0] data_out;
    logic        operation_done;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int busy_cnt = 0;

    typedef struct {
        logic [31:0] exp;
        int          n;
        int          acc_cyc;
    } exp_t;
    exp_t exp_q[$];

    enc_dec_hamming_encoder #(.DATA_WIDTH(32), .CNT_WIDTH(5)) dut (
        .clk(clk), .rst(rst), .start(start), .codeword_width(codeword_width),
        .data_in(data_in), .noise(noise), .busy(busy), .data_out(data_out),
        .operation_done(operation_done)
    );

    always #5 clk = ~clk;

    function automatic int n_of(input logic [1:0] w);
        return (w == 2'd0) ? 8 : (w == 2'd1) ? 16 : 32;
    endfunction

    // Reference: walk positions 1..n-1, fill non-powers-of-two with data, then add parity.
    function automatic logic [31:0] model(input int n, input logic [31:0] d, input logic [31:0] nz);
        logic [31:0] r = '0;
        int j = 0;
        int syn = 0;
        int ones = 0;
        for (int p = 1; p < n; p++) begin
            if ((p & (p - 1)) != 0) begin
                r[p-1] = d[j];
                if (d[j]) syn = syn ^ p;
                j++;
            end
        end
        for (int k = 0; (1 << k) < n; k++)
            r[(1 << k) - 1] = ((syn >> k) & 1) != 0;
        for (int b = 0; b < n - 1; b++)
            if (r[b]) ones++;
        r[n-1] = (ones % 2) == 1;
`ifdef ENC_NOISE_EN
        for (int b = 0; b < n; b++)
            r[b] = r[b] ^ nz[b];
`else
        if (nz != nz) r = '0;
`endif
        return r;
    endfunction

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (rst) begin
                busy_cnt = 0;
            end else begin
                if (busy) busy_cnt++;
                if (operation_done) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_done: data_out=%h with no pending encode at cycle %0d", data_out, cyc);
                    end else begin
                        exp_t e;
                        e = exp_q.pop_front();
                        checks += 3;
                        if (data_out !== e.exp) begin
                            errors++;
                            $display("FAIL data_out: got %h expected %h (N=%0d)", data_out, e.exp, e.n);
                        end
                        if (cyc - e.acc_cyc != e.n - 1) begin
                            errors++;
                            $display("FAIL latency: got %0d cycles expected %0d (N=%0d)", cyc - e.acc_cyc, e.n - 1, e.n);
                        end
                        if (busy_cnt != e.n - 1) begin
                            errors++;
                            $display("FAIL busy_cycles: got %0d expected %0d (N=%0d)", busy_cnt, e.n - 1, e.n);
                        end
                    end
                    busy_cnt = 0;
                end
            end
        end
    end

    task automatic issue(input logic [1:0] w, input logic [31:0] d, input logic [31:0] nz,
                         input logic [31:0] expv);
        int t = 0;
        @(negedge clk);
        while (busy && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (busy) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout: busy=%b expected 0", busy);
        end
        codeword_width = w;
        data_in = d;
        noise = nz;
        start = 1'b1;
        @(posedge clk);
        #1;
        exp_q.push_back('{expv, n_of(w), cyc});
        @(negedge clk);
        start = 1'b0;
        codeword_width = 2'($urandom);
        data_in = $urandom;
        noise = $urandom;
    endtask

    task automatic drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d encodes pending, expected 0", exp_q.size());
            exp_q.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    initial begin
        logic [1:0]  w;
        logic [31:0] d;
        logic [31:0] nz;
        rst = 1'b1;
        start = 1'b0;
        codeword_width = 2'd0;
        data_in = '0;
        noise = '0;
        repeat (3) @(negedge clk);
        checks += 3;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        if (operation_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", operation_done); end
        if (data_out !== 32'h0) begin errors++; $display("FAIL reset_data_out: got %h expected 0", data_out); end
        rst = 1'b0;

        issue(2'd0, 32'h0000000B, 32'h0, 32'h00000055);
        issue(2'd0, 32'h0000000F, 32'h0, 32'h000000FF);
        issue(2'd0, 32'h00000000, 32'h0, 32'h00000000);
`ifdef ENC_NOISE_EN
        issue(2'd0, 32'h0000000B, 32'h00000101, 32'h00000054);
`else
        issue(2'd0, 32'h0000000B, 32'h00000101, 32'h00000055);
`endif
        issue(2'd2, 32'h03FFFFFF, 32'h0, 32'hFFFFFFFF);
        issue(2'd3, 32'h03FFFFFF, 32'h0, 32'hFFFFFFFF);
        drain();

        // start re-pulsed while busy must be ignored
        issue(2'd1, 32'h000005A5, 32'h0, model(16, 32'h000005A5, 32'h0));
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        drain();

        // reset in the middle of CALC
        issue(2'd2, 32'h02345678, 32'h0, model(32, 32'h02345678, 32'h0));
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #1;
        checks += 2;
        if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b expected 0", busy); end
        if (data_out !== 32'h0) begin errors++; $display("FAIL abort_data_out: got %h expected 0", data_out); end
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        issue(2'd1, 32'h00000321, 32'h0, model(16, 32'h00000321, 32'h0));
        drain();

        for (int i = 0; i < 40; i++) begin
            w = 2'($urandom);
            d = $urandom;
            nz = ($urandom_range(0, 1) == 1) ? 32'($urandom) : 32'h0;
            issue(w, d, nz, model(n_of(w), d, nz));
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule
